// File: rtl/debug_mem_scanner.sv
// debug_mem_scanner
// Background sweeper for the debug console's memory-dump panel. Once per
// frame it reads WORDS consecutive words from the ROM or RAM window over a
// req/ack port and presents each committed word as a stable MEM_Addr /
// MEM_Data pair. Reads that are never acknowledged time out and commit
// 32'hDEAD_BEEF so a hung memory cannot stall the console.

module debug_mem_scanner #(
    parameter logic [31:0] ROM_BASE = 32'h0000_0000,
    parameter logic [31:0] RAM_BASE = 32'h0000_0000,
    parameter int          WORDS    = 128,
    parameter int          TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        sel_ram,
    input  logic        frame_tick,
    output logic        rd_req,
    output logic [31:0] rd_addr,
    input  logic        rd_ack,
    input  logic [31:0] rd_data,
    output logic [31:0] MEM_Addr,
    output logic [31:0] MEM_Data,
    output logic        busy,
    output logic        sweep_done,
    output logic [7:0]  err_cnt
);

    localparam logic [1:0]  ST_IDLE  = 2'd0;
    localparam logic [1:0]  ST_REQ   = 2'd1;
    localparam logic [1:0]  ST_GAP   = 2'd2;

    localparam logic [6:0]  LAST_IDX = 7'(WORDS - 1);
    localparam logic [7:0]  LAST_T   = 8'(TIMEOUT - 1);
    localparam logic [31:0] BAD_WORD = 32'hDEAD_BEEF;

    logic [1:0]  state_q,    state_d;
    logic [6:0]  idx_q,      idx_d;
    logic [7:0]  tcnt_q,     tcnt_d;
    logic        sel_q,      sel_d;
    logic [31:0] rd_addr_q,  rd_addr_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_data_q, mem_data_d;
    logic [7:0]  err_cnt_q,  err_cnt_d;

    // A window switch mid-sweep abandons the sweep; it wins over any commit
    // in the same cycle so the displayed pair keeps its last real value.
    logic abort;
    assign abort = (state_q != ST_IDLE) && (sel_ram != sel_q);

    // Next-state logic for the sweep sequencer and all datapath registers.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case leaves it unassigned and no latch is inferred.
        state_d    = state_q;
        idx_d      = idx_q;
        tcnt_d     = tcnt_q;
        sel_d      = sel_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        err_cnt_d  = err_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (frame_tick && en) begin
                    idx_d   = '0;
                    tcnt_d  = '0;
                    sel_d   = sel_ram;
                    state_d = ST_REQ;
                end
            end

            ST_REQ: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (rd_ack) begin
                    // An ack in the last timeout cycle still commits real data.
                    mem_addr_d = rd_addr_q;
                    mem_data_d = rd_data;
                    state_d    = ST_GAP;
                end else if (tcnt_q == LAST_T) begin
                    mem_addr_d = rd_addr_q;
                    mem_data_d = BAD_WORD;
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                    state_d = ST_GAP;
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                end
            end

            ST_GAP: begin
                // The gap cycle keeps MEM_* stable for two cycles between
                // commits and drops rd_req so stale acks are ignored.
                if (abort || (idx_q == LAST_IDX)) begin
                    state_d = ST_IDLE;
                end else begin
                    idx_d   = idx_q + 7'd1;
                    tcnt_d  = '0;
                    state_d = ST_REQ;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // Address is computed from the next index so it is already valid in
        // the first REQ cycle and holds for the whole request.
        rd_addr_d = (sel_d ? RAM_BASE : ROM_BASE) + {23'd0, idx_d, 2'b00};
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so all
        // registers see the pre-edge values of each other.
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            tcnt_q     <= '0;
            sel_q      <= 1'b0;
            rd_addr_q  <= ROM_BASE;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            tcnt_q     <= tcnt_d;
            sel_q      <= sel_d;
            rd_addr_q  <= rd_addr_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // rd_req is withdrawn in the reset cycle itself so an outstanding read
    // is abandoned without waiting for the registered state to clear.
    assign rd_req     = (state_q == ST_REQ) && !rst;
    assign rd_addr    = rd_addr_q;
    assign MEM_Addr   = mem_addr_q;
    assign MEM_Data   = mem_data_q;
    assign busy       = (state_q != ST_IDLE);
    assign sweep_done = (state_q == ST_GAP) && (idx_q == LAST_IDX) && !abort;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_debug_mem_scanner.sv
// Directed testbench for debug_mem_scanner: a behavioural memory slave with
// programmable ack latency, a per-cycle sweep monitor, and hand-computed
// expectations for each scenario.

module tb_debug_mem_scanner;

    localparam logic [31:0] RAM_B = 32'h0000_1000;
    localparam logic [31:0] DEAD  = 32'hDEAD_BEEF;
    localparam int          NONE  = -1;

    logic        clk = 1'b0;
    logic        rst, en, sel_ram, frame_tick, rd_ack;
    logic [31:0] rd_data;
    logic        rd_req, busy, sweep_done;
    logic [31:0] rd_addr, MEM_Addr, MEM_Data;
    logic [7:0]  err_cnt;

    always #5 clk = ~clk;

    debug_mem_scanner #(
        .ROM_BASE (32'h0000_0000),
        .RAM_BASE (RAM_B),
        .WORDS    (128),
        .TIMEOUT  (15)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .sel_ram    (sel_ram),
        .frame_tick (frame_tick),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_ack     (rd_ack),
        .rd_data    (rd_data),
        .MEM_Addr   (MEM_Addr),
        .MEM_Data   (MEM_Data),
        .busy       (busy),
        .sweep_done (sweep_done),
        .err_cnt    (err_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Contents of the model memory at a byte address.
    function automatic logic [31:0] model(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    // Memory slave: acks after ack_wait cycles of rd_req (0 = same cycle);
    // address sp_addr uses sp_wait instead. A wait of 255 never acks.
    int          ack_wait = 0;
    int          sp_wait  = 0;
    logic [31:0] sp_addr  = 32'hFFFF_FFFF;
    int          ack_cnt  = 0;

    initial begin
        rd_ack  = 1'b0;
        rd_data = '0;
        forever begin
            @(negedge clk);
            if (rd_req === 1'b1) begin
                rd_ack  = (ack_cnt == ((rd_addr == sp_addr) ? sp_wait : ack_wait));
                rd_data = rd_ack ? model(rd_addr) : 32'h0BAD_0BAD;
                ack_cnt++;
            end else begin
                ack_cnt = 0;
                rd_ack  = 1'b0;
                rd_data = '0;
            end
        end
    end

    // Sweep monitor results.
    int          req_len[$];
    logic [31:0] req_addr[$];
    logic [31:0] cm_addr[$];
    logic [31:0] cm_data[$];
    int          n_runs, done_cnt, done_cycle, busy_cycles, addr_glitch;

    // One-cycle frame_tick pulse; returns at the falling edge of cycle 1.
    task automatic start_tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    // Follows a sweep cycle by cycle until busy drops. Each rd_req run is
    // recorded with its start address and length; MEM_* is captured in the
    // cycle after the run ends. tog_at / tick_at flip sel_ram or pulse
    // frame_tick at the start of that request run.
    task automatic watch(input int budget, input int tog_at, input int tick_at);
        int          cyc;
        int          len;
        int          runs;
        bit          prev;
        bit          expired;
        logic [31:0] run_addr;
        cyc = 1; len = 0; runs = 0; prev = 1'b0; expired = 1'b0; run_addr = '0;
        req_len.delete(); req_addr.delete(); cm_addr.delete(); cm_data.delete();
        done_cnt = 0; done_cycle = -1; busy_cycles = 0; addr_glitch = 0;
        forever begin
            if (frame_tick) frame_tick = 1'b0;
            if (rd_req && !prev) begin
                req_addr.push_back(rd_addr);
                run_addr = rd_addr;
                len      = 1;
                if (runs == tog_at)  sel_ram    = ~sel_ram;
                if (runs == tick_at) frame_tick = 1'b1;
                runs++;
            end else if (rd_req && prev) begin
                len++;
                if (rd_addr !== run_addr) addr_glitch++;
            end else if (!rd_req && prev) begin
                req_len.push_back(len);
                cm_addr.push_back(MEM_Addr);
                cm_data.push_back(MEM_Data);
            end
            if (sweep_done) begin
                done_cnt++;
                done_cycle = cyc;
            end
            prev = rd_req;
            if (!busy) break;
            busy_cycles++;
            if (cyc >= budget) begin
                expired = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        check("watch_budget", 32'(expired), 32'd0);
        n_runs = req_len.size();
        while (req_len.size()  < 128) req_len.push_back(-1);
        while (req_addr.size() < 128) req_addr.push_back(32'hFFFF_FFFF);
        while (cm_addr.size()  < 128) cm_addr.push_back(32'hFFFF_FFFF);
        while (cm_data.size()  < 128) cm_data.push_back(32'hFFFF_FFFF);
    endtask

    // Checks a whole sweep against base + 4*i and the model memory,
    // skipping one word that the caller checks by hand.
    task automatic verify_sweep(input string tag, input logic [31:0] base,
                                input int exp_len, input int skip);
        int          bad_len;
        int          bad_addr;
        int          bad_data;
        logic [31:0] a;
        bad_len = 0; bad_addr = 0; bad_data = 0;
        for (int i = 0; i < 128; i++) begin
            if (i == skip) continue;
            a = base + 32'(4 * i);
            if (req_len[i] != exp_len) bad_len++;
            if (req_addr[i] !== a || cm_addr[i] !== a) bad_addr++;
            if (cm_data[i] !== model(a)) bad_data++;
        end
        check({tag, "_words"},     32'(n_runs),      32'd128);
        check({tag, "_bad_len"},   32'(bad_len),     32'd0);
        check({tag, "_bad_addr"},  32'(bad_addr),    32'd0);
        check({tag, "_bad_data"},  32'(bad_data),    32'd0);
        check({tag, "_addr_hold"}, 32'(addr_glitch), 32'd0);
        check({tag, "_done_cnt"},  32'(done_cnt),    32'd1);
    endtask

    initial begin
        #900_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst = 1'b1; en = 1'b1; sel_ram = 1'b0; frame_tick = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset values.
        check("rst_rd_req",   32'(rd_req),     32'd0);
        check("rst_rd_addr",  rd_addr,         32'h0);
        check("rst_mem_addr", MEM_Addr,        32'h0);
        check("rst_mem_data", MEM_Data,        32'h0);
        check("rst_busy",     32'(busy),       32'd0);
        check("rst_done",     32'(sweep_done), 32'd0);
        check("rst_err",      32'(err_cnt),    32'd0);

        // frame_tick with en low does not start a sweep.
        en = 1'b0;
        start_tick();
        check("en0_busy", 32'(busy), 32'd0);
        en = 1'b1;

        // T1: ROM, zero-wait: request at cycle 1, done at cycle 256.
        start_tick();
        check("t1_req_c1",  32'(rd_req), 32'd1);
        check("t1_addr_c1", rd_addr,     32'h0);
        watch(4000, NONE, NONE);
        verify_sweep("t1", 32'h0, 1, NONE);
        check("t1_done_cycle", 32'(done_cycle),  32'd256);
        check("t1_busy_cyc",   32'(busy_cycles), 32'd256);
        check("t1_w5_addr",    cm_addr[5],       32'h14);
        check("t1_err",        32'(err_cnt),     32'd0);

        // T2: RAM, 3 wait cycles; en dropped mid-sweep has no effect.
        sel_ram = 1'b1; ack_wait = 3;
        start_tick();
        en = 1'b0;
        watch(4000, NONE, NONE);
        en = 1'b1;
        verify_sweep("t2", RAM_B, 4, NONE);
        check("t2_w1_addr",    req_addr[1],      32'h1004);
        check("t2_done_cycle", 32'(done_cycle),  32'd640);
        check("t2_busy_cyc",   32'(busy_cycles), 32'd640);

        // T3: ROM, no ack on word 5 -> 15-cycle timeout and DEAD_BEEF.
        sel_ram = 1'b0; ack_wait = 0; sp_addr = 32'h14; sp_wait = 255;
        start_tick();
        watch(4000, NONE, NONE);
        verify_sweep("t3", 32'h0, 1, 5);
        check("t3_w5_len",   32'(req_len[5]),  32'd15);
        check("t3_w5_addr",  cm_addr[5],       32'h14);
        check("t3_w5_data",  cm_data[5],       DEAD);
        check("t3_err",      32'(err_cnt),     32'd1);
        check("t3_w6_addr",  req_addr[6],      32'h18);
        check("t3_busy_cyc", 32'(busy_cycles), 32'd270);

        // T3b: ack in the final timeout cycle wins over the timeout.
        sp_addr = 32'h08; sp_wait = 14;
        start_tick();
        watch(4000, NONE, NONE);
        verify_sweep("t3b", 32'h0, 1, 2);
        check("t3b_w2_len",  32'(req_len[2]), 32'd15);
        check("t3b_w2_data", cm_data[2],      model(32'h08));
        check("t3b_err",     32'(err_cnt),    32'd1);
        sp_addr = 32'hFFFF_FFFF;

        // T4: sel_ram flips at word 40 -> abort, no done, MEM_* held.
        start_tick();
        watch(4000, 40, NONE);
        check("t4_runs",     32'(n_runs),      32'd41);
        check("t4_w40_len",  32'(req_len[40]), 32'd1);
        check("t4_hold_adr", cm_addr[40],      32'h9C);
        check("t4_hold_dat", cm_data[40],      model(32'h9C));
        check("t4_done_cnt", 32'(done_cnt),    32'd0);
        check("t4_busy_cyc", 32'(busy_cycles), 32'd81);
        @(negedge clk);
        check("t4_idle_busy", 32'(busy),  32'd0);
        check("t4_idle_madr", MEM_Addr,   32'h9C);
        start_tick();
        check("t4_rst_req",  32'(rd_req), 32'd1);
        check("t4_rst_addr", rd_addr,     RAM_B);
        watch(4000, NONE, NONE);
        verify_sweep("t4r", RAM_B, 1, NONE);

        // T5: frame_tick while busy is ignored and not queued.
        start_tick();
        watch(4000, NONE, 10);
        verify_sweep("t5", RAM_B, 1, NONE);
        check("t5_busy_cyc", 32'(busy_cycles), 32'd256);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_no_queue", 32'(busy), 32'd0);
        end

        // T6: reset in the middle of a RAM request.
        ack_wait = 5;
        start_tick();
        repeat (7) @(negedge clk);
        check("t6_pre_req",  32'(rd_req), 32'd1);
        check("t6_pre_addr", rd_addr,     32'h1004);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_rd_req",   32'(rd_req),     32'd0);
        check("t6_rd_addr",  rd_addr,         32'h0);
        check("t6_mem_addr", MEM_Addr,        32'h0);
        check("t6_mem_data", MEM_Data,        32'h0);
        check("t6_busy",     32'(busy),       32'd0);
        check("t6_done",     32'(sweep_done), 32'd0);
        check("t6_err",      32'(err_cnt),    32'd0);
        @(negedge clk);
        check("t6_stay_idle", 32'(busy), 32'd0);

        // T7: every read times out; err_cnt saturates at 255.
        sel_ram = 1'b0; ack_wait = 255;
        start_tick();
        watch(4000, NONE, NONE);
        check("t7_busy_cyc", 32'(busy_cycles), 32'd2048);
        check("t7_w0_data",  cm_data[0],       DEAD);
        check("t7_w0_len",   32'(req_len[0]),  32'd15);
        check("t7_err_128",  32'(err_cnt),     32'd128);
        start_tick();
        watch(4000, NONE, NONE);
        check("t7_err_sat",  32'(err_cnt),     32'd255);
        start_tick();
        watch(4000, NONE, NONE);
        check("t7_err_hold", 32'(err_cnt),     32'd255);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
